pa_dcache_data_way_array: RTL and testbench

Parametrised, multi-way D-cache data array with byte-enabled writes, a one-entry posted write buffer and read-data merging. It replaces the single-way, fixed-size data array and sits between the LSU cache controller and per-way SRAM macros. It returns all ways of one index per read and retires writes to SRAM in cycles with no read, under a starvation bound.

---
 rtl/pa_dcache_pkg.sv | 35 +++
 rtl/gated_clk_cell.sv | 25 ++
 rtl/pa_dcache_data_way_array_sram.sv | 30 +++
 rtl/pa_dcache_data_way_array.sv | 137 +++++++++++++
 tb/tb_pa_dcache_data_way_array.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pa_dcache_pkg.sv
// Shared types and helpers for the D-cache data way array.
// - be_w():    derives the byte-enable width from a data width.
// - wb_entry_t: posted write-buffer entry (vld, idx, way, be, data), sized to
//               the largest supported configuration; users slice the low bits.
// - be2wen():  expands active-high byte enables to an active-low bit WEN mask.
package pa_dcache_pkg;

   localparam int MAX_WAYS   = 4;
   localparam int MAX_IDX_W  = 16;
   localparam int MAX_DATA_W = 128;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

   typedef struct packed {
      logic                  vld;
      logic [MAX_IDX_W-1:0]  idx;
      logic [MAX_WAYS-1:0]   way;
      logic [MAX_BE_W-1:0]   be;
      logic [MAX_DATA_W-1:0] data;
   } wb_entry_t;

   // A set byte enable clears the eight WEN bits of that byte (write them).
   function automatic logic [MAX_DATA_W-1:0] be2wen(input logic [MAX_BE_W-1:0] be);
      logic [MAX_DATA_W-1:0] wen;
      wen = '1;
      for (int b = 0; b < MAX_BE_W; b++) begin
         wen[b*8 +: 8] = {8{~be[b]}};
      end
      return wen;
   endfunction

endpackage

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate.
// Ports: clk_in (free clock), global_en, module_en, local_en, external_en,
//        pad_yy_icg_scan_en (forces the clock on in scan), clk_out (gated).
// The enable is captured while clk_in is low so clk_out never glitches.
module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic external_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);

   logic en_lat;

   always_latch begin
      if (!clk_in) begin
         en_lat <= (global_en && (module_en || local_en)) || external_en || pad_yy_icg_scan_en;
      end
   end

   assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/pa_dcache_data_way_array_sram.sv
// Behavioural single-port SRAM model (one per way).
// Ports: A address, CEN chip enable (low), CLK, GWEN global write enable
//        (low), D write data, WEN per-bit write enable (low), Q read data.
// Reads are synchronous; Q holds its value until the next read.
module pa_spsram_param #(
   parameter int DEPTH_W = 8,
   parameter int DATA_W  = 32
) (
   input  logic [DEPTH_W-1:0] A,
   input  logic               CEN,
   input  logic               CLK,
   input  logic               GWEN,
   input  logic [DATA_W-1:0]  D,
   output logic [DATA_W-1:0]  Q,
   input  logic [DATA_W-1:0]  WEN
);

   logic [DATA_W-1:0] mem [2**DEPTH_W];

   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) begin
            mem[A] <= (mem[A] & WEN) | (D & ~WEN);
         end else begin
            Q <= mem[A];
         end
      end
   end

endmodule

// File: rtl/pa_dcache_data_way_array.sv
// Multi-way D-cache data array with a one-entry posted write buffer.
// Ports: forever_cpuclk/cpurst clock and async active-high reset;
//        cp0_lsu_icg_en, pad_yy_icg_scan_en clock-gate controls;
//        req_* request (read returns all ways at req_idx, write posts to WB);
//        req_rdy accept; rd_vld/rd_dout read return (way w at w*DATA_W);
//        wb_empty write buffer status.
// Writes retire to SRAM in cycles with no accepted read; after STARVE_MAX
// consecutive blocked cycles one read is refused so the entry can drain.
module pa_dcache_data_way_array
   import pa_dcache_pkg::*;
#(
   parameter int WAYS       = 2,
   parameter int INDEX_W    = 8,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   localparam int BE_W      = be_w(DATA_W)
) (
   input  logic                   forever_cpuclk,
   input  logic                   cpurst,
   input  logic                   cp0_lsu_icg_en,
   input  logic                   pad_yy_icg_scan_en,
   input  logic                   req_vld,
   input  logic                   req_wr,
   input  logic [INDEX_W-1:0]     req_idx,
   input  logic [WAYS-1:0]        req_way,
   input  logic [BE_W-1:0]        req_be,
   input  logic [DATA_W-1:0]      req_din,
   output logic                   req_rdy,
   output logic                   rd_vld,
   output logic [WAYS*DATA_W-1:0] rd_dout,
   output logic                   wb_empty
);

   localparam int SCNT_W = $clog2(STARVE_MAX + 1);

   wb_entry_t                  wb;
   logic [SCNT_W-1:0]          starve_cnt;
   logic                       rd_acc, wr_acc, force_drain, drain;
   logic                       m_hit;
   logic [WAYS-1:0]            m_way;
   logic [BE_W-1:0]            m_be;
   logic [DATA_W-1:0]          m_data;
   logic [WAYS-1:0][DATA_W-1:0] q;
   logic [DATA_W-1:0]          wen;
   logic                       wb_unused;

   assign force_drain = wb.vld && (starve_cnt == SCNT_W'(STARVE_MAX));
   // A write cycle never reads, so the old entry always drains: writes are
   // never refused.
   assign req_rdy  = req_wr || !force_drain;
   assign rd_acc   = req_vld && !req_wr && req_rdy;
   assign wr_acc   = req_vld && req_wr;
   assign drain    = wb.vld && !rd_acc;
   assign wb_empty = !wb.vld;
   assign wen      = DATA_W'(be2wen(wb.be));
   // Folds the high, configuration-unused bits of the entry into one net.
   assign wb_unused = ^{wb.idx, wb.way, wb.be, wb.data};

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         wb <= '0;
      end else if (wr_acc) begin
         wb.vld  <= 1'b1;
         wb.idx  <= MAX_IDX_W'(req_idx);
         wb.way  <= MAX_WAYS'(req_way);
         wb.be   <= MAX_BE_W'(req_be);
         wb.data <= MAX_DATA_W'(req_din);
      end else if (drain) begin
         wb.vld <= 1'b0;
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         starve_cnt <= '0;
      end else if (!wb.vld || drain) begin
         starve_cnt <= '0;
      end else if (starve_cnt != SCNT_W'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Snapshot of the WB at read accept; bytes it covers override SRAM Q.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         rd_vld <= 1'b0;
         m_hit  <= 1'b0;
         m_way  <= '0;
         m_be   <= '0;
         m_data <= '0;
      end else begin
         rd_vld <= rd_acc;
         if (rd_acc) begin
            m_hit  <= wb.vld && (wb.idx == MAX_IDX_W'(req_idx));
            m_way  <= wb.way[WAYS-1:0];
            m_be   <= wb.be[BE_W-1:0];
            m_data <= wb.data[DATA_W-1:0];
         end
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic gclk, wr_sel;
      assign wr_sel = drain && wb.way[w];

      gated_clk_cell u_icg (
         .clk_in             (forever_cpuclk),
         .global_en          (1'b1),
         .module_en          (cp0_lsu_icg_en),
         .local_en           (rd_acc || wr_sel),
         .external_en        (1'b0),
         .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
         .clk_out            (gclk)
      );

      pa_spsram_param #(.DEPTH_W(INDEX_W), .DATA_W(DATA_W)) u_sram (
         .A    (wr_sel ? wb.idx[INDEX_W-1:0] : req_idx),
         .CEN  (!(rd_acc || wr_sel)),
         .CLK  (gclk),
         .GWEN (!wr_sel),
         .D    (wb.data[DATA_W-1:0]),
         .Q    (q[w]),
         .WEN  (wen)
      );

      for (genvar b = 0; b < BE_W; b++) begin : g_byte
         assign rd_dout[w*DATA_W + b*8 +: 8] =
            !rd_vld                          ? 8'h00 :
            (m_hit && m_way[w] && m_be[b])   ? m_data[b*8 +: 8] :
                                               q[w][b*8 +: 8];
      end
   end

   a_way_onehot: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
      (req_vld && req_wr) |-> $onehot(req_way));

endmodule

// File: tb/tb_pa_dcache_data_way_array.sv
module tb_pa_dcache_data_way_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        vld = 0, wr = 0;
  logic [7:0]  idx = 0;
  logic [1:0]  way = 0;
  logic [3:0]  be  = 0;
  logic [31:0] din = 0;
  logic        rdy, rvld, wbe;
  logic [63:0] dout;

  pa_dcache_data_way_array u_d2 (
    .forever_cpuclk(clk), .cpurst(rst), .cp0_lsu_icg_en(1'b0), .pad_yy_icg_scan_en(1'b0),
    .req_vld(vld), .req_wr(wr), .req_idx(idx), .req_way(way), .req_be(be), .req_din(din),
    .req_rdy(rdy), .rd_vld(rvld), .rd_dout(dout), .wb_empty(wbe)
  );

  logic         v4 = 0, w4 = 0;
  logic [7:0]   i4 = 0;
  logic [3:0]   way4 = 0;
  logic [7:0]   be4 = 0;
  logic [63:0]  din4 = 0;
  logic         rdy4, rvld4, wbe4;
  logic [255:0] dout4;

  pa_dcache_data_way_array #(.WAYS(4), .DATA_W(64)) u_d4 (
    .forever_cpuclk(clk), .cpurst(rst), .cp0_lsu_icg_en(1'b0), .pad_yy_icg_scan_en(1'b0),
    .req_vld(v4), .req_wr(w4), .req_idx(i4), .req_way(way4), .req_be(be4), .req_din(din4),
    .req_rdy(rdy4), .rd_vld(rvld4), .rd_dout(dout4), .wb_empty(wbe4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_req(input logic [7:0] i, input logic [1:0] wy, input logic [3:0] b,
                        input logic [31:0] d);
    vld = 1; wr = 1; idx = i; way = wy; be = b; din = d;
  endtask

  task automatic rd_req(input logic [7:0] i);
    vld = 1; wr = 0; idx = i; way = 2'b01; be = 0; din = 0;
  endtask

  task automatic idle();
    vld = 0; wr = 0; way = 2'b01;
  endtask

  logic [63:0] pat [4];
  logic        e1;

  initial begin
    pat[0] = 64'h1111_2222_3333_4444;
    pat[1] = 64'h5555_6666_7777_8888;
    pat[2] = 64'h9999_AAAA_BBBB_CCCC;
    pat[3] = 64'hDDDD_EEEE_FFFF_0123;
    way = 2'b01; way4 = 4'b0001;

    #2;
    total++; if (rvld !== 1'b0) begin bad++; $error("FAIL rst_rd_vld observed=%0h expected=0", rvld); end
    total++; if (wbe !== 1'b1) begin bad++; $error("FAIL rst_wb_empty observed=%0h expected=1", wbe); end
    total++; if (rdy !== 1'b1) begin bad++; $error("FAIL rst_req_rdy observed=%0h expected=1", rdy); end
    total++; if (dout !== 64'h0) begin bad++; $error("FAIL rst_rd_dout observed=%0h expected=0", dout); end
    total++; if (wbe4 !== 1'b1) begin bad++; $error("FAIL rst_wb_empty4 observed=%0h expected=1", wbe4); end
    tick(); tick();
    rst = 0;

    wr_req(8'h10, 2'b01, 4'hF, 32'hA5A5A5A5);
    tick();
    total++; if (wbe !== 1'b0) begin bad++; $error("FAIL t1_wb_full observed=%0h expected=0", wbe); end
    idle();
    tick();
    total++; if (wbe !== 1'b1) begin bad++; $error("FAIL t1_wb_drained observed=%0h expected=1", wbe); end
    rd_req(8'h10);
    total++; if (rdy !== 1'b1) begin bad++; $error("FAIL t1_rdy observed=%0h expected=1", rdy); end
    tick();
    total++; if (rvld !== 1'b1) begin bad++; $error("FAIL t1_rd_vld observed=%0h expected=1", rvld); end
    total++; if (dout[31:0] !== 32'hA5A5A5A5) begin bad++; $error("FAIL t1_way0 observed=%0h expected=a5a5a5a5", dout[31:0]); end
    idle();
    tick();
    total++; if (rvld !== 1'b0) begin bad++; $error("FAIL t1_rd_vld_low observed=%0h expected=0", rvld); end

    wr_req(8'h20, 2'b10, 4'hF, 32'h11223344); tick(); idle(); tick();
    wr_req(8'h20, 2'b01, 4'hF, 32'hCAFEF00D); tick(); idle(); tick();
    wr_req(8'h20, 2'b10, 4'h3, 32'h0000BEEF); tick();
    rd_req(8'h20);
    tick();
    total++; if (rvld !== 1'b1) begin bad++; $error("FAIL t2_rd_vld observed=%0h expected=1", rvld); end
    total++; if (dout[63:32] !== 32'h1122BEEF) begin bad++; $error("FAIL t2_way1_merge observed=%0h expected=1122beef", dout[63:32]); end
    total++; if (dout[31:0] !== 32'hCAFEF00D) begin bad++; $error("FAIL t2_way0 observed=%0h expected=cafef00d", dout[31:0]); end
    idle(); tick();
    total++; if (wbe !== 1'b1) begin bad++; $error("FAIL t2_wb_drained observed=%0h expected=1", wbe); end
    rd_req(8'h20); tick();
    total++; if (dout[63:32] !== 32'h1122BEEF) begin bad++; $error("FAIL t2_way1_sram observed=%0h expected=1122beef", dout[63:32]); end

    wr_req(8'h30, 2'b01, 4'hF, 32'hDEADBEEF); tick();
    for (int i = 1; i <= 6; i++) begin
      rd_req(8'h30);
      e1 = (i == 5) ? 1'b0 : 1'b1;
      total++; if (rdy !== e1) begin bad++; $error("FAIL t3_req_rdy observed=%0h expected=%0h", rdy, e1); end
      tick();
      total++; if (rvld !== e1) begin bad++; $error("FAIL t3_rd_vld observed=%0h expected=%0h", rvld, e1); end
      if (i != 5) begin
        total++; if (dout[31:0] !== 32'hDEADBEEF) begin bad++; $error("FAIL t3_way0 observed=%0h expected=deadbeef", dout[31:0]); end
      end
      e1 = (i >= 5) ? 1'b1 : 1'b0;
      total++; if (wbe !== e1) begin bad++; $error("FAIL t3_wb_empty observed=%0h expected=%0h", wbe, e1); end
    end
    idle(); tick();

    wr_req(8'h50, 2'b01, 4'hF, 32'h12345678);
    total++; if (rdy !== 1'b1) begin bad++; $error("FAIL t4_rdy_a observed=%0h expected=1", rdy); end
    tick();
    wr_req(8'h51, 2'b10, 4'hF, 32'h87654321);
    total++; if (rdy !== 1'b1) begin bad++; $error("FAIL t4_rdy_b observed=%0h expected=1", rdy); end
    tick();
    total++; if (wbe !== 1'b0) begin bad++; $error("FAIL t4_wb_full observed=%0h expected=0", wbe); end
    idle(); tick();
    rd_req(8'h50); tick();
    total++; if (dout[31:0] !== 32'h12345678) begin bad++; $error("FAIL t4_rd_a observed=%0h expected=12345678", dout[31:0]); end
    rd_req(8'h51); tick();
    total++; if (dout[63:32] !== 32'h87654321) begin bad++; $error("FAIL t4_rd_b observed=%0h expected=87654321", dout[63:32]); end

    wr_req(8'h60, 2'b01, 4'hF, 32'h0BADCAFE); tick(); idle(); tick();
    wr_req(8'h60, 2'b01, 4'hF, 32'hFFFFFFFF); tick();
    rd_req(8'h60); tick();
    total++; if (rvld !== 1'b1) begin bad++; $error("FAIL t5_rd_vld_pre observed=%0h expected=1", rvld); end
    idle();
    rst = 1;
    #1;
    total++; if (rvld !== 1'b0) begin bad++; $error("FAIL t5_rd_vld_async observed=%0h expected=0", rvld); end
    tick();
    total++; if (rvld !== 1'b0) begin bad++; $error("FAIL t5_rd_vld observed=%0h expected=0", rvld); end
    total++; if (wbe !== 1'b1) begin bad++; $error("FAIL t5_wb_empty observed=%0h expected=1", wbe); end
    total++; if (dout !== 64'h0) begin bad++; $error("FAIL t5_rd_dout observed=%0h expected=0", dout); end
    rst = 0;
    rd_req(8'h60); tick();
    total++; if (dout[31:0] !== 32'h0BADCAFE) begin bad++; $error("FAIL t5_sram_kept observed=%0h expected=0badcafe", dout[31:0]); end
    idle(); tick();

    for (int w = 0; w < 4; w++) begin
      v4 = 1; w4 = 1; i4 = 8'h05; way4 = 4'b0001 << w; be4 = 8'hFF; din4 = pat[w];
      total++; if (rdy4 !== 1'b1) begin bad++; $error("FAIL t6_rdy_wr observed=%0h expected=1", rdy4); end
      tick();
    end
    v4 = 1; w4 = 0; i4 = 8'h05; way4 = 4'b0001;
    tick();
    total++; if (rvld4 !== 1'b1) begin bad++; $error("FAIL t6_rd_vld observed=%0h expected=1", rvld4); end
    for (int w = 0; w < 4; w++) begin
      total++; if (dout4[w*64 +: 64] !== pat[w]) begin bad++; $error("FAIL t6_way_slice observed=%0h expected=%0h", dout4[w*64 +: 64], pat[w]); end
    end
    v4 = 0; tick(); tick();
    total++; if (wbe4 !== 1'b1) begin bad++; $error("FAIL t6_wb_empty observed=%0h expected=1", wbe4); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
